// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and default latencies for the HI/LO unit.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // True for the multi-cycle ops (MULT, MULTU, DIV, DIVU).
  function automatic logic is_arith(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result generator: product or quotient/remainder pair.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] hi_p_o,
  output logic [31:0] lo_p_o,
  output logic        div_by_zero_o
);

  logic [63:0] prod;
  logic [31:0] rt_safe;

  // Select the operation result; a zero divisor is replaced by 1 so the
  // divider never sees 0, and the flag tells the sequencer not to commit.
  always_comb begin
    prod          = 64'd0;
    hi_p_o        = 32'd0;
    lo_p_o        = 32'd0;
    div_by_zero_o = 1'b0;
    rt_safe       = (rt_i == 32'd0) ? 32'd1 : rt_i;
    case (op_i)
      MD_MULT: begin
        // Low 64 bits of the sign-extended product equal the signed product.
        prod   = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
        hi_p_o = prod[63:32];
        lo_p_o = prod[31:0];
      end
      MD_MULTU: begin
        prod   = {32'd0, rs_i} * {32'd0, rt_i};
        hi_p_o = prod[63:32];
        lo_p_o = prod[31:0];
      end
      MD_DIV: begin
        // SystemVerilog signed / and % truncate toward zero; remainder
        // carries the dividend sign.
        lo_p_o        = $signed(rs_i) / $signed(rt_safe);
        hi_p_o        = $signed(rs_i) % $signed(rt_safe);
        div_by_zero_o = (rt_i == 32'd0);
      end
      MD_DIVU: begin
        lo_p_o        = rs_i / rt_safe;
        hi_p_o        = rs_i % rt_safe;
        div_by_zero_o = (rt_i == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// HI/LO multiply/divide sequencer: fixed-latency countdown, commit at
// completion, MT*/MF* handling and stall request toward the hazard unit.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        md_valid,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  input  logic        cancel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] md_res,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_state_e  dbg_state
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       hip_q, hip_d, lop_q, lop_d;
  logic              nc_q, nc_d;

  logic [31:0]       calc_hi, calc_lo;
  logic              calc_dz;
  logic              start, mt_ok;

  mdu_calc u_calc (
    .op_i          (md_op),
    .rs_i          (rs_val),
    .rt_i          (rt_val),
    .hi_p_o        (calc_hi),
    .lo_p_o        (calc_lo),
    .div_by_zero_o (calc_dz)
  );

  assign start = md_valid & is_arith(md_op) & (state_q == ST_IDLE) & ~cancel;
  assign mt_ok = md_valid & (state_q == ST_IDLE) & ~cancel;

  // Next-state logic: start/MT* in IDLE, countdown/commit/cancel in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hip_d   = hip_q;
    lop_d   = lop_q;
    nc_d    = nc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hip_d   = calc_hi;
          lop_d   = calc_lo;
          nc_d    = calc_dz;
          cnt_d   = (md_op == MD_MULT || md_op == MD_MULTU) ?
                    CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_d = ST_BUSY;
        end else if (mt_ok && md_op == MD_MTHI) begin
          hi_d = rs_val;
        end else if (mt_ok && md_op == MD_MTLO) begin
          lo_d = rs_val;
        end
      end
      ST_BUSY: begin
        // Cancel wins over the commit on the final countdown edge.
        if (cancel) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            if (!nc_q) begin
              hi_d = hip_q;
              lo_d = lop_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and architectural registers; asynchronous reset drops any op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hip_q   <= 32'd0;
      lop_q   <= 32'd0;
      nc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hip_q   <= hip_d;
      lop_q   <= lop_d;
      nc_q    <= nc_d;
    end
  end

  // Move-from result mux; not gated by md_valid.
  always_comb begin
    md_res = 32'd0;
    if (md_op == MD_MFHI)      md_res = hi_q;
    else if (md_op == MD_MFLO) md_res = lo_q;
  end

  assign busy      = (state_q == ST_BUSY);
  assign stall_req = d_is_md & (start | busy);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, results, cancel and reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  md_op = MD_NONE;
  logic        md_valid = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        d_is_md = 1'b0;
  logic        cancel = 1'b0;
  logic        busy, stall_req;
  logic [31:0] md_res, hi, lo;
  mdu_state_e  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .md_valid  (md_valid),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_is_md   (d_is_md),
    .cancel    (cancel),
    .busy      (busy),
    .stall_req (stall_req),
    .md_res    (md_res),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    md_op    = MD_NONE;
    md_valid = 1'b0;
    rs_val   = 32'd0;
    rt_val   = 32'd0;
    cancel   = 1'b0;
  endtask

  // Issue an MT* op for one cycle.
  task automatic move_to(input logic [3:0] op, input logic [31:0] v);
    md_op = op; md_valid = 1'b1; rs_val = v;
    step();
    drive_idle();
  endtask

  // Start an arithmetic op with d_is_md held high and measure its busy window.
  task automatic run_arith(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int n);
    logic [31:0] hi_old, lo_old;
    int cnt;
    hi_old = hi; lo_old = lo;
    md_op = op; md_valid = 1'b1; rs_val = a; rt_val = b; d_is_md = 1'b1;
    #1;
    check({tag, "_stall_start"}, {31'd0, stall_req}, 32'd1);
    step();
    drive_idle();
    check({tag, "_hi_hold"}, hi, hi_old);
    check({tag, "_lo_hold"}, lo, lo_old);
    cnt = 0;
    while (busy && cnt < 40) begin
      if (stall_req !== 1'b1) check({tag, "_stall_busy"}, {31'd0, stall_req}, 32'd1);
      cnt++;
      step();
    end
    check({tag, "_busy_cycles"}, cnt, n);
    check({tag, "_stall_after"}, {31'd0, stall_req}, 32'd0);
    d_is_md = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_md_res", md_res, 32'd0);
    reset = 1'b1;
    step();
    check("rst_stall", {31'd0, stall_req}, 32'd0);

    // MULT / MULTU of -2 x 3
    run_arith("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);
    md_op = MD_MFLO; #1;
    check("mflo_prod", md_res, 32'hFFFFFFFA);
    md_op = MD_MFHI; #1;
    check("mfhi_prod", md_res, 32'hFFFFFFFF);
    md_op = MD_NONE;
    run_arith("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 5);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);

    // DIV -7/2 and DIVU 7/2
    run_arith("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    run_arith("divu", MD_DIVU, 32'd7, 32'd2, 10);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // MTHI then divide by zero: no commit, full latency
    move_to(MD_MTHI, 32'h1234);
    check("mthi_hi", hi, 32'h1234);
    run_arith("div0", MD_DIV, 32'd55, 32'd0, 10);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'd3);

    // MTHI while busy is ignored
    md_op = MD_MULTU; md_valid = 1'b1; rs_val = 32'd6; rt_val = 32'd7;
    step();
    md_op = MD_MTHI; rs_val = 32'hBAD0;
    step();
    drive_idle();
    repeat (5) step();
    check("busy_mthi_ign_hi", hi, 32'd0);
    check("busy_mthi_lo", lo, 32'd42);

    // Cancel on the counter==1 cycle of DIV 100/7
    md_op = MD_DIV; md_valid = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    step();
    drive_idle();
    repeat (9) step();
    check("cancel_busy_pre", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_hi", hi, 32'd0);
    check("cancel_lo", lo, 32'd42);

    // Cancel suppresses MTLO and an arithmetic start
    md_op = MD_MTLO; md_valid = 1'b1; rs_val = 32'hDEAD; cancel = 1'b1;
    step();
    check("cancel_mtlo", lo, 32'd42);
    md_op = MD_MULT; rs_val = 32'd2; rt_val = 32'd2; d_is_md = 1'b1; #1;
    check("cancel_start_stall", {31'd0, stall_req}, 32'd0);
    step();
    check("cancel_start_busy", {31'd0, busy}, 32'd0);
    drive_idle(); d_is_md = 1'b0;
    move_to(MD_MTLO, 32'hDEAD);
    check("mtlo_lo", lo, 32'hDEAD);
    move_to(MD_MTHI, 32'h55);

    // Asynchronous reset mid-MULT
    md_op = MD_MULT; md_valid = 1'b1; rs_val = 32'd3; rt_val = 32'd4;
    step();
    drive_idle();
    step();
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) step();
    check("arst_no_commit_hi", hi, 32'd0);
    check("arst_no_commit_lo", lo, 32'd0);
    check("arst_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
